issue_queue: RTL and testbench

Unified reservation station between dispatch and the three functional units. It accepts up to two renamed instructions per cycle and holds them until both source operands are valid. Operand values come from dispatch or from the complete stage's forwarding buses (`f_flag_k` / `dest_r_k` / `f_data_k`). The queue then issues at most one ready instruction per FU per cycle. The FU results feed the complete stage through `result_*_k`.

---
 rtl/issue_queue.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue
//
// Unified reservation station sitting between dispatch and the three
// functional units. Up to two renamed instructions are accepted per cycle and
// parked until both source operands hold valid values. Operands arrive either
// with the instruction or from the three forwarding buses of the complete
// stage. Each cycle at most one ready instruction is issued per FU.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   disp_*_1 / disp_*_2      dispatch slots (valid, fu, aluop, two sources
//                            {tag, rdy, val}, dest tag, ROB index)
//   f_flag_k, dest_r_k,      forwarding buses k = 1..3 from complete
//   f_data_k
//   iq_full                  fewer than two free entries (upstream must stall)
//   free_count               number of free entries, registered
//   fu_valid_k .. fu_rob_k   issue registers towards FU k-1 (k = 1..3)
// ----------------------------------------------------------------------------
module issue_queue #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 6,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     disp_valid_1,
   input  logic [1:0]               disp_fu_1,
   input  logic [3:0]               disp_aluop_1,
   input  logic [TAG_W-1:0]         disp_src1_tag_1,
   input  logic [TAG_W-1:0]         disp_src2_tag_1,
   input  logic                     disp_src1_rdy_1,
   input  logic                     disp_src2_rdy_1,
   input  logic [XLEN-1:0]          disp_src1_val_1,
   input  logic [XLEN-1:0]          disp_src2_val_1,
   input  logic [TAG_W-1:0]         disp_dest_1,
   input  logic [3:0]               disp_rob_1,

   input  logic                     disp_valid_2,
   input  logic [1:0]               disp_fu_2,
   input  logic [3:0]               disp_aluop_2,
   input  logic [TAG_W-1:0]         disp_src1_tag_2,
   input  logic [TAG_W-1:0]         disp_src2_tag_2,
   input  logic                     disp_src1_rdy_2,
   input  logic                     disp_src2_rdy_2,
   input  logic [XLEN-1:0]          disp_src1_val_2,
   input  logic [XLEN-1:0]          disp_src2_val_2,
   input  logic [TAG_W-1:0]         disp_dest_2,
   input  logic [3:0]               disp_rob_2,

   input  logic                     f_flag_1,
   input  logic [TAG_W-1:0]         dest_r_1,
   input  logic [XLEN-1:0]          f_data_1,
   input  logic                     f_flag_2,
   input  logic [TAG_W-1:0]         dest_r_2,
   input  logic [XLEN-1:0]          f_data_2,
   input  logic                     f_flag_3,
   input  logic [TAG_W-1:0]         dest_r_3,
   input  logic [XLEN-1:0]          f_data_3,

   output logic                     iq_full,
   output logic [$clog2(DEPTH):0]   free_count,

   output logic                     fu_valid_1,
   output logic [3:0]               fu_aluop_1,
   output logic [XLEN-1:0]          fu_a_1,
   output logic [XLEN-1:0]          fu_b_1,
   output logic [TAG_W-1:0]         fu_dest_1,
   output logic [3:0]               fu_rob_1,

   output logic                     fu_valid_2,
   output logic [3:0]               fu_aluop_2,
   output logic [XLEN-1:0]          fu_a_2,
   output logic [XLEN-1:0]          fu_b_2,
   output logic [TAG_W-1:0]         fu_dest_2,
   output logic [3:0]               fu_rob_2,

   output logic                     fu_valid_3,
   output logic [3:0]               fu_aluop_3,
   output logic [XLEN-1:0]          fu_a_3,
   output logic [XLEN-1:0]          fu_b_3,
   output logic [TAG_W-1:0]         fu_dest_3,
   output logic [3:0]               fu_rob_3
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int N_FU  = 3;
   localparam int N_FWD = 3;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             rdy;
      logic [XLEN-1:0]  val;
   } opnd_t;

   typedef struct packed {
      logic [1:0]       fu;
      logic [3:0]       aluop;
      opnd_t            src1;
      opnd_t            src2;
      logic [TAG_W-1:0] dest;
      logic [3:0]       rob;
   } entry_t;

   typedef struct packed {
      logic   valid;
      entry_t e;
   } disp_t;

   // -------------------------------------------------------------------------
   // Flatten the numbered ports into arrays
   // -------------------------------------------------------------------------
   disp_t            disp   [2];
   logic [N_FWD-1:0] f_flag;
   logic [TAG_W-1:0] f_tag  [N_FWD];
   logic [XLEN-1:0]  f_data [N_FWD];

   assign disp[0] = '{valid: disp_valid_1,
                      e: '{fu: disp_fu_1, aluop: disp_aluop_1,
                           src1: '{tag: disp_src1_tag_1, rdy: disp_src1_rdy_1, val: disp_src1_val_1},
                           src2: '{tag: disp_src2_tag_1, rdy: disp_src2_rdy_1, val: disp_src2_val_1},
                           dest: disp_dest_1, rob: disp_rob_1}};
   assign disp[1] = '{valid: disp_valid_2,
                      e: '{fu: disp_fu_2, aluop: disp_aluop_2,
                           src1: '{tag: disp_src1_tag_2, rdy: disp_src1_rdy_2, val: disp_src1_val_2},
                           src2: '{tag: disp_src2_tag_2, rdy: disp_src2_rdy_2, val: disp_src2_val_2},
                           dest: disp_dest_2, rob: disp_rob_2}};

   assign f_flag    = {f_flag_3, f_flag_2, f_flag_1};
   assign f_tag[0]  = dest_r_1;
   assign f_tag[1]  = dest_r_2;
   assign f_tag[2]  = dest_r_3;
   assign f_data[0] = f_data_1;
   assign f_data[1] = f_data_2;
   assign f_data[2] = f_data_3;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [DEPTH-1:0] valid_q, valid_d;
   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [CNT_W-1:0] free_count_q;

   logic [N_FU-1:0]  fu_valid_q;
   logic [3:0]       fu_aluop_q [N_FU];
   logic [XLEN-1:0]  fu_a_q     [N_FU];
   logic [XLEN-1:0]  fu_b_q     [N_FU];
   logic [TAG_W-1:0] fu_dest_q  [N_FU];
   logic [3:0]       fu_rob_q   [N_FU];

   // Capture a forwarded value for a still-waiting operand. Buses are scanned
   // from the highest index down so the lowest matching bus has the last word.
   function automatic opnd_t wake(input opnd_t o);
      opnd_t r;
      r = o;
      if (!o.rdy) begin
         for (int j = N_FWD - 1; j >= 0; j--) begin
            if (f_flag[j] && (f_tag[j] == o.tag)) begin
               r.rdy = 1'b1;
               r.val = f_data[j];
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] count_ones(input logic [DEPTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   // -------------------------------------------------------------------------
   // Free-entry search: lowest and second-lowest free slot of the registered
   // valid vector, so entries freed by this cycle's issue are not reused yet.
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0] free1_idx, free2_idx;

   // NOTE: blocking assignments in always_comb; the second loop must see the
   // free1_idx value computed just above it in the same pass.
   always_comb begin
      free1_idx = '0;
      free2_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid_q[i]) free1_idx = IDX_W'(i);
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid_q[i] && (IDX_W'(i) != free1_idx)) free2_idx = IDX_W'(i);
   end

   // A slot consumes an entry only when it is valid, targets a real FU and the
   // queue was not full at the start of the cycle. Slot 2 falls back to the
   // lowest free entry when slot 1 takes none.
   logic [1:0]       take;
   logic [IDX_W-1:0] alloc_idx [2];

   always_comb begin
      for (int s = 0; s < 2; s++)
         take[s] = !iq_full && disp[s].valid && (disp[s].e.fu != 2'd3);
      alloc_idx[0] = free1_idx;
      alloc_idx[1] = take[0] ? free2_idx : free1_idx;
   end

   // -------------------------------------------------------------------------
   // Select: per FU, lowest-index valid entry with both operands ready, looked
   // up in registered state only.
   // -------------------------------------------------------------------------
   logic [N_FU-1:0]  sel_hit;
   logic [IDX_W-1:0] sel_idx [N_FU];

   always_comb begin
      sel_hit = '0;
      for (int f = 0; f < N_FU; f++) begin
         sel_idx[f] = '0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (ent_q[i].fu == 2'(f)) &&
                ent_q[i].src1.rdy && ent_q[i].src2.rdy) begin
               sel_hit[f] = 1'b1;
               sel_idx[f] = IDX_W'(i);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state for valid bits and entry payloads
   // -------------------------------------------------------------------------
   // NOTE: every always_comb output is given a full default before any
   // conditional update, so no path leaves a signal unassigned (no latch).
   always_comb begin
      valid_d = valid_q;
      for (int f = 0; f < N_FU; f++)
         if (sel_hit[f]) valid_d[sel_idx[f]] = 1'b0;
      for (int s = 0; s < 2; s++)
         if (take[s]) valid_d[alloc_idx[s]] = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (valid_q[i]) begin
            ent_d[i].src1 = wake(ent_q[i].src1);
            ent_d[i].src2 = wake(ent_q[i].src2);
         end
      end
      // Newly written entries pick up same-cycle forwards (insert bypass).
      for (int s = 0; s < 2; s++) begin
         if (take[s]) begin
            ent_d[alloc_idx[s]]      = disp[s].e;
            ent_d[alloc_idx[s]].src1 = wake(disp[s].e.src1);
            ent_d[alloc_idx[s]].src2 = wake(disp[s].e.src2);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // NOTE: payload storage has no reset; an entry's contents are only ever
   // looked at while its valid bit is set, and valid_q is reset.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         free_count_q <= CNT_W'(DEPTH);
         fu_valid_q   <= '0;
         for (int f = 0; f < N_FU; f++) begin
            fu_aluop_q[f] <= '0;
            fu_a_q[f]     <= '0;
            fu_b_q[f]     <= '0;
            fu_dest_q[f]  <= '0;
            fu_rob_q[f]   <= '0;
         end
      end else begin
         valid_q      <= valid_d;
         free_count_q <= CNT_W'(DEPTH) - count_ones(valid_d);
         fu_valid_q   <= sel_hit;
         // Data registers only load on issue so they hold between pulses.
         for (int f = 0; f < N_FU; f++) begin
            if (sel_hit[f]) begin
               fu_aluop_q[f] <= ent_q[sel_idx[f]].aluop;
               fu_a_q[f]     <= ent_q[sel_idx[f]].src1.val;
               fu_b_q[f]     <= ent_q[sel_idx[f]].src2.val;
               fu_dest_q[f]  <= ent_q[sel_idx[f]].dest;
               fu_rob_q[f]   <= ent_q[sel_idx[f]].rob;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign free_count = free_count_q;
   assign iq_full    = (free_count_q < CNT_W'(2));

   assign fu_valid_1 = fu_valid_q[0];
   assign fu_aluop_1 = fu_aluop_q[0];
   assign fu_a_1     = fu_a_q[0];
   assign fu_b_1     = fu_b_q[0];
   assign fu_dest_1  = fu_dest_q[0];
   assign fu_rob_1   = fu_rob_q[0];

   assign fu_valid_2 = fu_valid_q[1];
   assign fu_aluop_2 = fu_aluop_q[1];
   assign fu_a_2     = fu_a_q[1];
   assign fu_b_2     = fu_b_q[1];
   assign fu_dest_2  = fu_dest_q[1];
   assign fu_rob_2   = fu_rob_q[1];

   assign fu_valid_3 = fu_valid_q[2];
   assign fu_aluop_3 = fu_aluop_q[2];
   assign fu_a_3     = fu_a_q[2];
   assign fu_b_3     = fu_b_q[2];
   assign fu_dest_3  = fu_dest_q[2];
   assign fu_rob_3   = fu_rob_q[2];

endmodule

// File: tb/tb_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_issue_queue
//
// Directed bench for issue_queue with hand-computed expectations. Inputs are
// driven 1 time unit after the rising edge and outputs sampled at the same
// point, so each step() call advances exactly one clock edge.
// ----------------------------------------------------------------------------
module tb_issue_queue;

   logic        clk;
   logic        rst;

   logic        disp_valid_1, disp_valid_2;
   logic [1:0]  disp_fu_1, disp_fu_2;
   logic [3:0]  disp_aluop_1, disp_aluop_2;
   logic [5:0]  disp_src1_tag_1, disp_src2_tag_1, disp_src1_tag_2, disp_src2_tag_2;
   logic        disp_src1_rdy_1, disp_src2_rdy_1, disp_src1_rdy_2, disp_src2_rdy_2;
   logic [31:0] disp_src1_val_1, disp_src2_val_1, disp_src1_val_2, disp_src2_val_2;
   logic [5:0]  disp_dest_1, disp_dest_2;
   logic [3:0]  disp_rob_1, disp_rob_2;

   logic        f_flag_1, f_flag_2, f_flag_3;
   logic [5:0]  dest_r_1, dest_r_2, dest_r_3;
   logic [31:0] f_data_1, f_data_2, f_data_3;

   logic        iq_full;
   logic [4:0]  free_count;
   logic        fu_valid_1, fu_valid_2, fu_valid_3;
   logic [3:0]  fu_aluop_1, fu_aluop_2, fu_aluop_3;
   logic [31:0] fu_a_1, fu_a_2, fu_a_3;
   logic [31:0] fu_b_1, fu_b_2, fu_b_3;
   logic [5:0]  fu_dest_1, fu_dest_2, fu_dest_3;
   logic [3:0]  fu_rob_1, fu_rob_2, fu_rob_3;

   int n_total = 0;
   int n_bad   = 0;

   issue_queue #(.DEPTH(16), .TAG_W(6), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .disp_valid_1(disp_valid_1), .disp_fu_1(disp_fu_1), .disp_aluop_1(disp_aluop_1),
      .disp_src1_tag_1(disp_src1_tag_1), .disp_src2_tag_1(disp_src2_tag_1),
      .disp_src1_rdy_1(disp_src1_rdy_1), .disp_src2_rdy_1(disp_src2_rdy_1),
      .disp_src1_val_1(disp_src1_val_1), .disp_src2_val_1(disp_src2_val_1),
      .disp_dest_1(disp_dest_1), .disp_rob_1(disp_rob_1),
      .disp_valid_2(disp_valid_2), .disp_fu_2(disp_fu_2), .disp_aluop_2(disp_aluop_2),
      .disp_src1_tag_2(disp_src1_tag_2), .disp_src2_tag_2(disp_src2_tag_2),
      .disp_src1_rdy_2(disp_src1_rdy_2), .disp_src2_rdy_2(disp_src2_rdy_2),
      .disp_src1_val_2(disp_src1_val_2), .disp_src2_val_2(disp_src2_val_2),
      .disp_dest_2(disp_dest_2), .disp_rob_2(disp_rob_2),
      .f_flag_1(f_flag_1), .dest_r_1(dest_r_1), .f_data_1(f_data_1),
      .f_flag_2(f_flag_2), .dest_r_2(dest_r_2), .f_data_2(f_data_2),
      .f_flag_3(f_flag_3), .dest_r_3(dest_r_3), .f_data_3(f_data_3),
      .iq_full(iq_full), .free_count(free_count),
      .fu_valid_1(fu_valid_1), .fu_aluop_1(fu_aluop_1), .fu_a_1(fu_a_1), .fu_b_1(fu_b_1),
      .fu_dest_1(fu_dest_1), .fu_rob_1(fu_rob_1),
      .fu_valid_2(fu_valid_2), .fu_aluop_2(fu_aluop_2), .fu_a_2(fu_a_2), .fu_b_2(fu_b_2),
      .fu_dest_2(fu_dest_2), .fu_rob_2(fu_rob_2),
      .fu_valid_3(fu_valid_3), .fu_aluop_3(fu_aluop_3), .fu_a_3(fu_a_3), .fu_b_3(fu_b_3),
      .fu_dest_3(fu_dest_3), .fu_rob_3(fu_rob_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      disp_valid_1 = 0; disp_fu_1 = 0; disp_aluop_1 = 0;
      disp_src1_tag_1 = 0; disp_src2_tag_1 = 0; disp_src1_rdy_1 = 0; disp_src2_rdy_1 = 0;
      disp_src1_val_1 = 0; disp_src2_val_1 = 0; disp_dest_1 = 0; disp_rob_1 = 0;
      disp_valid_2 = 0; disp_fu_2 = 0; disp_aluop_2 = 0;
      disp_src1_tag_2 = 0; disp_src2_tag_2 = 0; disp_src1_rdy_2 = 0; disp_src2_rdy_2 = 0;
      disp_src1_val_2 = 0; disp_src2_val_2 = 0; disp_dest_2 = 0; disp_rob_2 = 0;
      f_flag_1 = 0; dest_r_1 = 0; f_data_1 = 0;
      f_flag_2 = 0; dest_r_2 = 0; f_data_2 = 0;
      f_flag_3 = 0; dest_r_3 = 0; f_data_3 = 0;
   endtask

   task automatic disp(input int s, input logic [1:0] fu, input logic [3:0] op,
                       input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                       input logic [5:0] dest, input logic [3:0] rob);
      if (s == 1) begin
         disp_valid_1 = 1; disp_fu_1 = fu; disp_aluop_1 = op;
         disp_src1_tag_1 = t1; disp_src1_rdy_1 = r1; disp_src1_val_1 = v1;
         disp_src2_tag_1 = t2; disp_src2_rdy_1 = r2; disp_src2_val_1 = v2;
         disp_dest_1 = dest; disp_rob_1 = rob;
      end else begin
         disp_valid_2 = 1; disp_fu_2 = fu; disp_aluop_2 = op;
         disp_src1_tag_2 = t1; disp_src1_rdy_2 = r1; disp_src1_val_2 = v1;
         disp_src2_tag_2 = t2; disp_src2_rdy_2 = r2; disp_src2_val_2 = v2;
         disp_dest_2 = dest; disp_rob_2 = rob;
      end
   endtask

   task automatic fwd(input int k, input logic [5:0] tag, input logic [31:0] data);
      case (k)
         1: begin f_flag_1 = 1; dest_r_1 = tag; f_data_1 = data; end
         2: begin f_flag_2 = 1; dest_r_2 = tag; f_data_2 = data; end
         default: begin f_flag_3 = 1; dest_r_3 = tag; f_data_3 = data; end
      endcase
   endtask

   initial begin
      clear_in();
      rst = 1;
      #1;
      step();
      step();

      // Reset state
      check("rst_free", 32'(free_count), 32'd16);
      check("rst_full", 32'(iq_full), 32'd0);
      check("rst_valid", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd0);
      check("rst_a1", fu_a_1, 32'd0);
      rst = 0;

      // Two ready FU0 ops: issue on consecutive cycles in entry order
      disp(1, 2'd0, 4'd1, 6'd1, 1, 32'd1, 6'd2, 1, 32'd2, 6'd10, 4'd1);
      disp(2, 2'd0, 4'd2, 6'd3, 1, 32'd3, 6'd4, 1, 32'd4, 6'd11, 4'd2);
      step();
      clear_in();
      check("t1_free14", 32'(free_count), 32'd14);
      check("t1_noissue", 32'(fu_valid_1), 32'd0);
      step();
      check("t1_v1", 32'(fu_valid_1), 32'd1);
      check("t1_a1", fu_a_1, 32'd1);
      check("t1_b1", fu_b_1, 32'd2);
      check("t1_dest1", 32'(fu_dest_1), 32'd10);
      check("t1_free15", 32'(free_count), 32'd15);
      step();
      check("t1_v2", 32'(fu_valid_1), 32'd1);
      check("t1_a2", fu_a_1, 32'd3);
      check("t1_b2", fu_b_1, 32'd4);
      check("t1_rob2", 32'(fu_rob_1), 32'd2);
      check("t1_free16", 32'(free_count), 32'd16);
      step();
      check("t1_pulse_end", 32'(fu_valid_1), 32'd0);
      check("t1_hold_a", fu_a_1, 32'd3);

      // FU1 op woken by forward bus 2 two cycles after dispatch
      disp(1, 2'd1, 4'd2, 6'd9, 0, 32'd0, 6'd33, 1, 32'd5, 6'd12, 4'd3);
      step();
      clear_in();
      check("t2_free15", 32'(free_count), 32'd15);
      step();
      check("t2_wait", 32'(fu_valid_2), 32'd0);
      fwd(2, 6'd9, 32'hDEAD);
      step();
      clear_in();
      check("t2_wake_edge", 32'(fu_valid_2), 32'd0);
      step();
      check("t2_v", 32'(fu_valid_2), 32'd1);
      check("t2_a", fu_a_2, 32'hDEAD);
      check("t2_b", fu_b_2, 32'd5);
      check("t2_dest", 32'(fu_dest_2), 32'd12);

      // Insert-time bypass; buses 1 and 3 both match, bus 1 must win
      disp(1, 2'd2, 4'd7, 6'd40, 1, 32'd100, 6'd5, 0, 32'd0, 6'd13, 4'd4);
      fwd(1, 6'd5, 32'd7);
      fwd(3, 6'd5, 32'd99);
      step();
      clear_in();
      check("t3_wait", 32'(fu_valid_3), 32'd0);
      step();
      check("t3_v", 32'(fu_valid_3), 32'd1);
      check("t3_a", fu_a_3, 32'd100);
      check("t3_b", fu_b_3, 32'd7);
      check("t3_op", 32'(fu_aluop_3), 32'd7);

      // Fill 15 entries with unready FU0 ops (src1 tags 20..34)
      for (int c = 0; c < 7; c++) begin
         clear_in();
         disp(1, 2'd0, 4'd1, 6'(20 + 2*c), 0, 32'd0, 6'd0, 1, 32'(256 + 20 + 2*c), 6'(20 + 2*c), 4'd0);
         disp(2, 2'd0, 4'd1, 6'(21 + 2*c), 0, 32'd0, 6'd0, 1, 32'(256 + 21 + 2*c), 6'(21 + 2*c), 4'd0);
         step();
      end
      clear_in();
      disp(1, 2'd0, 4'd1, 6'd34, 0, 32'd0, 6'd0, 1, 32'(256 + 34), 6'd34, 4'd0);
      step();
      clear_in();
      check("t4_free1", 32'(free_count), 32'd1);
      check("t4_full", 32'(iq_full), 32'd1);
      // Ready ops offered while full must be dropped
      disp(1, 2'd0, 4'd3, 6'd0, 1, 32'h111, 6'd0, 1, 32'h222, 6'd50, 4'd9);
      disp(2, 2'd0, 4'd3, 6'd0, 1, 32'h333, 6'd0, 1, 32'h444, 6'd51, 4'd9);
      step();
      clear_in();
      check("t4_drop_free", 32'(free_count), 32'd1);
      fwd(1, 6'd20, 32'hBEEF);
      step();
      clear_in();
      check("t4_drop_noissue", 32'(fu_valid_1), 32'd0);
      step();
      check("t4_v", 32'(fu_valid_1), 32'd1);
      check("t4_a", fu_a_1, 32'hBEEF);
      check("t4_b", fu_b_1, 32'd276);
      check("t4_dest", 32'(fu_dest_1), 32'd20);
      check("t4_free2", 32'(free_count), 32'd2);
      check("t4_notfull", 32'(iq_full), 32'd0);

      // Flush the remaining entries
      rst = 1;
      step();
      rst = 0;
      check("t4_flush_free", 32'(free_count), 32'd16);

      // One op per FU, dispatched over two cycles, all issue together
      disp(1, 2'd0, 4'd3, 6'd40, 0, 32'd0, 6'd1, 1, 32'd12, 6'd41, 4'd5);
      step();
      clear_in();
      disp(1, 2'd1, 4'd4, 6'd1, 1, 32'd21, 6'd1, 1, 32'd22, 6'd42, 4'd6);
      disp(2, 2'd2, 4'd5, 6'd1, 1, 32'd31, 6'd1, 1, 32'd32, 6'd43, 4'd7);
      fwd(1, 6'd40, 32'd11);
      step();
      clear_in();
      check("t5_none", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd0);
      step();
      check("t5_all3", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd7);
      check("t5_a1", fu_a_1, 32'd11);
      check("t5_b1", fu_b_1, 32'd12);
      check("t5_a2", fu_a_2, 32'd21);
      check("t5_rob2", 32'(fu_rob_2), 32'd6);
      check("t5_a3", fu_a_3, 32'd31);
      check("t5_b3", fu_b_3, 32'd32);
      check("t5_dest3", 32'(fu_dest_3), 32'd43);

      // Slot 1 with illegal FU is ignored; slot 2 still dispatches
      disp(1, 2'd3, 4'd8, 6'd1, 1, 32'h77, 6'd1, 1, 32'h78, 6'd45, 4'd8);
      disp(2, 2'd0, 4'd9, 6'd1, 1, 32'h55, 6'd1, 1, 32'h66, 6'd44, 4'd8);
      step();
      clear_in();
      check("t5b_free15", 32'(free_count), 32'd15);
      step();
      check("t5b_valid", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd1);
      check("t5b_a", fu_a_1, 32'h55);
      check("t5b_op", 32'(fu_aluop_1), 32'd9);
      check("t5b_free16", 32'(free_count), 32'd16);

      // Reset with six queued entries discards them
      disp(1, 2'd0, 4'd1, 6'd50, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      disp(2, 2'd1, 4'd1, 6'd51, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      step();
      clear_in();
      disp(1, 2'd2, 4'd1, 6'd52, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      disp(2, 2'd0, 4'd1, 6'd53, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      step();
      clear_in();
      disp(1, 2'd1, 4'd1, 6'd54, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      disp(2, 2'd2, 4'd1, 6'd55, 0, 32'd0, 6'd1, 1, 32'd1, 6'd1, 4'd1);
      step();
      clear_in();
      check("t6_free10", 32'(free_count), 32'd10);
      rst = 1;
      fwd(1, 6'd50, 32'd1);
      fwd(2, 6'd51, 32'd2);
      fwd(3, 6'd52, 32'd3);
      step();
      rst = 0;
      clear_in();
      check("t6_free16", 32'(free_count), 32'd16);
      check("t6_valid0", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd0);
      check("t6_a1_zero", fu_a_1, 32'd0);
      check("t6_b2_zero", fu_b_2, 32'd0);
      check("t6_dest3_zero", 32'(fu_dest_3), 32'd0);
      for (int c = 0; c < 4; c++) begin
         clear_in();
         fwd(1, 6'(50 + 3*(c % 2)), 32'd1);
         fwd(2, 6'(51 + 3*(c % 2)), 32'd2);
         fwd(3, 6'(52 + 3*(c % 2)), 32'd3);
         step();
         check("t6_no_ghost", 32'({fu_valid_3, fu_valid_2, fu_valid_1}), 32'd0);
      end
      clear_in();
      check("t6_free_end", 32'(free_count), 32'd16);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
